// File: rtl/morse_pkg.sv
// Shared symbol codes, sizing constants and FSM state type for the Morse character decoder.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_RSVD = 2'b10;
  localparam logic [1:0] SYM_PAD  = 2'b11;

  localparam int SEQ_W     = 10;
  localparam int NUM_SLOTS = 16;
  localparam int SYMS      = SEQ_W / 2;

  localparam logic [7:0] CHAR_UNKNOWN = 8'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Symbol pos 0 is the first (most significant) symbol of a sequence.
  function automatic logic [1:0] sym_at(input logic [SEQ_W-1:0] seq, input int pos);
    return seq[SEQ_W-1-2*pos -: 2];
  endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational Morse sequence to ASCII lookup with validity and pad-ordering checks.
// Digit patterns decode to '0'-'9' only when MORSE_DIGITS_EN is defined.
module morse_lut
  import morse_pkg::*;
(
  input  logic [SEQ_W-1:0] seq,
  output logic             valid,
  output logic [7:0]       ascii
);

  // D = dot, H = dash, P = pad
  localparam logic [1:0] D = SYM_DOT;
  localparam logic [1:0] H = SYM_DASH;
  localparam logic [1:0] P = SYM_PAD;

  logic       well_formed;
  logic       pad_seen;
  logic [7:0] lut_char;

  assign valid = (sym_at(seq, 0) != SYM_PAD);

  always_comb begin
    well_formed = 1'b1;
    pad_seen    = 1'b0;
    for (int i = 0; i < SYMS; i++) begin
      if (sym_at(seq, i) == SYM_RSVD) begin
        well_formed = 1'b0;
      end else if (sym_at(seq, i) == SYM_PAD) begin
        pad_seen = 1'b1;
      end else if (pad_seen) begin
        well_formed = 1'b0;
      end
    end
  end

  always_comb begin
    lut_char = CHAR_UNKNOWN;
    case (seq)
      {D, H, P, P, P}: lut_char = 8'h41;
      {H, D, D, D, P}: lut_char = 8'h42;
      {H, D, H, D, P}: lut_char = 8'h43;
      {H, D, D, P, P}: lut_char = 8'h44;
      {D, P, P, P, P}: lut_char = 8'h45;
      {D, D, H, D, P}: lut_char = 8'h46;
      {H, H, D, P, P}: lut_char = 8'h47;
      {D, D, D, D, P}: lut_char = 8'h48;
      {D, D, P, P, P}: lut_char = 8'h49;
      {D, H, H, H, P}: lut_char = 8'h4A;
      {H, D, H, P, P}: lut_char = 8'h4B;
      {D, H, D, D, P}: lut_char = 8'h4C;
      {H, H, P, P, P}: lut_char = 8'h4D;
      {H, D, P, P, P}: lut_char = 8'h4E;
      {H, H, H, P, P}: lut_char = 8'h4F;
      {D, H, H, D, P}: lut_char = 8'h50;
      {H, H, D, H, P}: lut_char = 8'h51;
      {D, H, D, P, P}: lut_char = 8'h52;
      {D, D, D, P, P}: lut_char = 8'h53;
      {H, P, P, P, P}: lut_char = 8'h54;
      {D, D, H, P, P}: lut_char = 8'h55;
      {D, D, D, H, P}: lut_char = 8'h56;
      {D, H, H, P, P}: lut_char = 8'h57;
      {H, D, D, H, P}: lut_char = 8'h58;
      {H, D, H, H, P}: lut_char = 8'h59;
      {H, H, D, D, P}: lut_char = 8'h5A;
`ifdef MORSE_DIGITS_EN
      {H, H, H, H, H}: lut_char = 8'h30;
      {D, H, H, H, H}: lut_char = 8'h31;
      {D, D, H, H, H}: lut_char = 8'h32;
      {D, D, D, H, H}: lut_char = 8'h33;
      {D, D, D, D, H}: lut_char = 8'h34;
      {D, D, D, D, D}: lut_char = 8'h35;
      {H, D, D, D, D}: lut_char = 8'h36;
      {H, H, D, D, D}: lut_char = 8'h37;
      {H, H, H, D, D}: lut_char = 8'h38;
      {H, H, H, H, D}: lut_char = 8'h39;
`endif
      default:         lut_char = CHAR_UNKNOWN;
    endcase
  end

  assign ascii = well_formed ? lut_char : CHAR_UNKNOWN;

endmodule

// File: rtl/morse_char_decoder.sv
// Walks a captured Morse storage snapshot oldest-first (top slot down to slot 0) and emits one
// ASCII character per valid slot over valid/ready. Digit decode is gated by MORSE_DIGITS_EN.
//
// state | meaning
// IDLE  | waiting for start; snapshot/idx/count loaded on start
// SCAN  | examine slot idx, skip empties
// EMIT  | char_valid high, wait for char_ready
// DONE  | one-cycle done pulse
module morse_char_decoder
  import morse_pkg::state_e, morse_pkg::IDLE, morse_pkg::SCAN, morse_pkg::EMIT, morse_pkg::DONE;
#(
  parameter int NUM_SLOTS = morse_pkg::NUM_SLOTS,
  parameter int SEQ_W     = morse_pkg::SEQ_W,
  parameter int CHAR_W    = 8
)(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_SLOTS*SEQ_W-1:0] seq_in,
  output logic [CHAR_W-1:0]          char_out,
  output logic                       char_valid,
  input  logic                       char_ready,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 count
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  state_e                     state;
  state_e                     state_nxt;
  logic [NUM_SLOTS*SEQ_W-1:0] snap;
  logic [IDX_W-1:0]           idx;
  logic [SEQ_W-1:0]           slot;
  logic                       slot_valid;
  logic [7:0]                 slot_char;

  assign slot = snap[int'(idx) * SEQ_W +: SEQ_W];

  morse_lut u_lut (
    .seq   (slot),
    .valid (slot_valid),
    .ascii (slot_char)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (slot_valid)     state_nxt = EMIT;
        else if (idx == '0) state_nxt = DONE;
      end
      EMIT: if (char_ready) state_nxt = (idx == '0) ? DONE : SCAN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    char_valid = (state == EMIT);
    done       = (state == DONE);
  end

  // Snapshot is frozen for the whole walk; char_out only changes in SCAN so it holds under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap     <= '0;
      idx      <= '0;
      char_out <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= seq_in;
            idx   <= IDX_W'(NUM_SLOTS - 1);
            count <= '0;
          end
        end
        SCAN: begin
          if (slot_valid)     char_out <= CHAR_W'(slot_char);
          else if (idx != '0) idx      <= idx - 1'b1;
        end
        EMIT: begin
          if (char_ready) begin
            count <= count + 5'd1;
            if (idx != '0) idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_char_decoder.sv
// Self-checking bench for morse_char_decoder: directed vectors, backpressure/reset corners and
// randomized walks against a string-based Morse reference model.
module tb_morse_char_decoder;

`ifdef MORSE_DIGITS_EN
  localparam bit DIGITS = 1'b1;
`else
  localparam bit DIGITS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         char_ready = 1'b0;
  logic [159:0] seq_in = '1;
  logic [7:0]   char_out;
  logic         char_valid;
  logic         busy;
  logic         done;
  logic [4:0]   count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [9:0] seq;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  string codes[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  morse_char_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .seq_in     (seq_in),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    string      code;
    bit         pad_seen;
    logic [1:0] sym;
    code     = "";
    pad_seen = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      sym = s[2*i +: 2];
      if (sym == 2'b10) return 8'h3F;
      if (sym == 2'b11) pad_seen = 1'b1;
      else if (pad_seen) return 8'h3F;
      else if (sym == 2'b01) code = {code, "-"};
      else code = {code, "."};
    end
    for (int i = 0; i < 26; i++) if (code == codes[i]) return 8'h41 + 8'(i);
    if (DIGITS) begin
      for (int i = 0; i < 10; i++) if (code == codes[26+i]) return 8'h30 + 8'(i);
    end
    return 8'h3F;
  endfunction

  function automatic logic [9:0] encode(input string c);
    logic [9:0] s;
    s = '1;
    for (int i = 0; i < c.len(); i++) s[9-2*i -: 2] = (c[i] == "-") ? 2'b01 : 2'b00;
    return s;
  endfunction

  task automatic model_walk(input logic [159:0] snap, output logic [7:0] exp[$]);
    exp.delete();
    for (int k = 15; k >= 0; k--) begin
      if (snap[10*k+9 -: 2] != 2'b11) exp.push_back(ref_decode(snap[10*k +: 10]));
    end
  endtask

  task automatic gen_snap(output logic [159:0] snap);
    int unsigned r;
    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(9);
      if (r < 4)      snap[10*k +: 10] = '1;
      else if (r < 8) snap[10*k +: 10] = encode(codes[$urandom_range(35)]);
      else            snap[10*k +: 10] = 10'($urandom);
    end
  endtask

  // Runs one walk; cycle n is observed at the n-th falling edge after the start edge.
  task automatic do_walk(input logic [159:0] snap, input int ready_pct, input int stall_n,
                         input bit glitch, input logic [159:0] glitch_snap,
                         output logic [7:0] got[$], output int valid_cycles, output int done_cyc);
    bit         held;
    logic [7:0] prev;
    int         stalls;
    got.delete();
    valid_cycles = 0;
    done_cyc     = -1;
    held         = 1'b0;
    prev         = '0;
    stalls       = 0;
    @(negedge clk);
    seq_in = snap; start = 1'b1; char_ready = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    seq_in = {5{$urandom()}};
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      if (held) check("hold_char", 32'({char_valid, char_out}), 32'({1'b1, prev}));
      if (done) begin
        done_cyc = cyc;
        break;
      end
      held = 1'b0;
      if (char_valid) begin
        valid_cycles++;
        if (stalls < stall_n) begin
          char_ready = 1'b0;
          stalls++;
        end else begin
          char_ready = ($urandom_range(99) < ready_pct);
        end
        if (char_ready) got.push_back(char_out);
        else begin
          held = 1'b1;
          prev = char_out;
        end
      end else begin
        char_ready = 1'($urandom_range(1));
      end
      start = glitch && (cyc == 3);
      if (glitch && cyc == 3) seq_in = glitch_snap;
      @(negedge clk);
    end
    start = 1'b0;
    char_ready = 1'b0;
    if (done_cyc < 0) begin
      check("walk_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("done_pulse_width", 32'({done, busy}), 32'd0);
    end
  endtask

  task automatic check_walk(input string tag, input logic [7:0] exp[$], input logic [7:0] got[$],
                            input int vcyc, input int dcyc);
    check({tag, "_nchars"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_char%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    check({tag, "_count"}, 32'(count), 32'(exp.size()));
    check({tag, "_done_cycle"}, 32'(dcyc), 32'(17 + vcyc));
  endtask

  initial begin
    logic [159:0] snap;
    logic [159:0] gsnap;
    logic [7:0]   exp[$];
    logic [7:0]   got[$];
    int           vc;
    int           dc;

    vecs[0]  = '{10'h07F, 8'h41};
    vecs[1]  = '{10'h00F, 8'h53};
    vecs[2]  = '{10'h0FF, 8'h45};
    vecs[3]  = '{10'h1FF, 8'h54};
    vecs[4]  = '{10'h117, 8'h59};
    vecs[5]  = '{10'h143, 8'h5A};
    vecs[6]  = '{10'h147, 8'h51};
    vecs[7]  = '{10'h155, DIGITS ? 8'h30 : 8'h3F};
    vecs[8]  = '{10'h000, DIGITS ? 8'h35 : 8'h3F};
    vecs[9]  = '{10'h154, DIGITS ? 8'h39 : 8'h3F};
    vecs[10] = '{10'h2FF, 8'h3F};
    vecs[11] = '{10'h0CF, 8'h3F};
    vecs[12] = '{10'h0BF, 8'h3F};
    vecs[13] = '{10'h017, 8'h3F};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_char_out", 32'(char_out), 32'd0);
    check("reset_flags", 32'({char_valid, busy, done}), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    reset_n = 1'b1;

    do_walk('1, 100, 0, 1'b0, '1, got, vc, dc);
    exp.delete();
    check_walk("empty", exp, got, vc, dc);
    check("empty_done_at_17", 32'(dc), 32'd17);

    snap = '1;
    snap[19:10] = 10'h07F;
    snap[9:0]   = 10'h00F;
    do_walk(snap, 100, 0, 1'b0, '1, got, vc, dc);
    exp = '{8'h41, 8'h53};
    check_walk("as", exp, got, vc, dc);
    check("as_done_at_19", 32'(dc), 32'd19);

    do_walk(snap, 100, 5, 1'b0, '1, got, vc, dc);
    check_walk("as_stall", exp, got, vc, dc);
    check("as_stall_done_at_24", 32'(dc), 32'd24);

    gsnap = {16{10'h0FF}};
    do_walk(snap, 100, 0, 1'b1, gsnap, got, vc, dc);
    check_walk("start_ignored", exp, got, vc, dc);

    for (int i = 0; i < 14; i++) begin
      snap = '1;
      snap[(i % 16) * 10 +: 10] = vecs[i].seq;
      do_walk(snap, 100, 0, 1'b0, '1, got, vc, dc);
      exp = '{vecs[i].exp};
      check_walk($sformatf("vec%0d", i), exp, got, vc, dc);
    end

    snap = '1;
    snap[159:150] = 10'h07F;
    @(negedge clk);
    seq_in = snap; start = 1'b1; char_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("rst_cycle1_scan", 32'({busy, char_valid}), 32'b10);
    @(negedge clk);
    check("rst_cycle2_emit", 32'({char_valid, char_out}), 32'({1'b1, 8'h41}));
    #2 reset_n = 1'b0;
    #1 check("rst_async_clear", 32'({char_out, char_valid, busy, done, count}), 32'd0);
    @(negedge clk);
    check("rst_held_clear", 32'({char_out, char_valid, busy, done, count}), 32'd0);
    reset_n = 1'b1;
    do_walk(snap, 100, 0, 1'b0, '1, got, vc, dc);
    exp = '{8'h41};
    check_walk("after_reset", exp, got, vc, dc);

    for (int n = 0; n < 25; n++) begin
      gen_snap(snap);
      model_walk(snap, exp);
      do_walk(snap, 30 + int'($urandom_range(70)), 0, 1'b0, '1, got, vc, dc);
      check_walk($sformatf("rand%0d", n), exp, got, vc, dc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
